// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch constants and the fetch FSM state type.
package instruction_fetch_pkg;
  localparam logic [31:0] INITIAL_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches the word at pc over req/gnt/rvalid and hands it to decode via valid/ready.
// Ports: clock/reset (async, active-high); pc, redirect from datapath; pc_write_enable back to PC;
// imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory bus; inst_valid/inst_ready/inst/inst_pc/inst_fault to decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INSTRUCTION,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        pc_write_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);
  fetch_state_t r_state, w_next_state;
  logic r_kill;
  logic w_misaligned;
  logic w_drop;
  assign w_misaligned = ALIGN_CHECK && (pc[1:0] != 2'b00);
  // a response is discarded if its fetch was redirected earlier or is being redirected now
  assign w_drop = r_kill | redirect;
  assign imem_req = r_state == ADDR;
  assign inst_valid = r_state == HOLD;
  assign pc_write_enable = inst_valid & inst_ready & ~redirect;
  always_comb begin
    w_next_state = r_state;
    w_next_state = r_state == IDLE ? (w_misaligned ? HOLD : ADDR)
                 : r_state == ADDR ? (imem_gnt ? DATA : ADDR)
                 : r_state == DATA ? (imem_rvalid ? (w_drop ? IDLE : HOLD) : DATA)
                 : ((redirect | inst_ready) ? IDLE : HOLD);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      imem_addr  <= INITIAL_PC;
      inst       <= NOP_INST;
      inst_pc    <= INITIAL_PC;
      inst_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_misaligned) begin
            inst_fault <= 1'b1;
            inst       <= NOP_INST;
            inst_pc    <= pc;
          end else begin
            imem_addr <= pc;
          end
        end
        ADDR: if (redirect) r_kill <= 1'b1;
        DATA: begin
          if (imem_rvalid) begin
            r_kill <= 1'b0;
            if (!w_drop) begin
              inst       <= imem_rdata;
              inst_pc    <= imem_addr;
              inst_fault <= 1'b0;
            end
          end else if (redirect) begin
            r_kill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  a_rvalid_in_data: assert property (@(posedge clock) disable iff (reset) imem_rvalid |-> r_state == DATA);
  a_req_stable: assert property (@(posedge clock) disable iff (reset)
    imem_req && !imem_gnt |=> imem_req && $stable(imem_addr));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch.
module tb_instruction_fetch;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] pc;
  logic redirect;
  logic pc_write_enable;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic inst_fault;
  int checks = 0;
  int errors = 0;
  logic [64:0] sb[$];
  logic [64:0] exp_item;
  instruction_fetch dut (
    .clock(clock), .reset(reset), .pc(pc), .redirect(redirect),
    .pc_write_enable(pc_write_enable), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );
  always #5 clock = ~clock;
  always begin
    @(negedge clock);
    #3;
    if (!reset) begin
      if (inst_valid && inst_ready && !redirect) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: handoff inst=%h pc=%h with nothing expected", inst, inst_pc);
        end else begin
          exp_item = sb.pop_front();
          if ({inst_fault, inst_pc, inst} !== exp_item || pc_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL sb_data: got fault=%b pc=%h inst=%h pwe=%b, need fault=%b pc=%h inst=%h pwe=1",
                     inst_fault, inst_pc, inst, pc_write_enable, exp_item[64], exp_item[63:32], exp_item[31:0]);
          end
        end
      end else if (pc_write_enable !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pwe_spurious: pwe=%b valid=%b ready=%b redirect=%b, need pwe=0",
                 pc_write_enable, inst_valid, inst_ready, redirect);
      end
    end
  end
  task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] data);
    pc = addr;
    inst_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h, need req=1 addr=%h", imem_req, imem_addr, addr);
    end
    imem_gnt = 1'b1;
    sb.push_back({1'b0, addr, data});
    @(negedge clock);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    @(negedge clock);
    checks++;
    if (inst_valid !== 1'b1 || pc_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b pwe=%b, need valid=1 pwe=1", inst_valid, pc_write_enable);
    end
    imem_rvalid = 1'b0;
    @(negedge clock);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || pc_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: valid=%b req=%b pwe=%b, need 0 0 0", inst_valid, imem_req, pc_write_enable);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || pc_write_enable !== 1'b0 || inst_fault !== 1'b0 ||
        imem_addr !== 32'h0 || inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%b req=%b pwe=%b fault=%b addr=%h inst=%h pc=%h, need 0 0 0 0 0 00000013 0",
               inst_valid, imem_req, pc_write_enable, inst_fault, imem_addr, inst, inst_pc);
    end
    reset = 1'b0;
  endtask
  task automatic test_basic();
    fetch_ok(32'h0, 32'h0050_0093);
  endtask
  task automatic test_stall();
    pc = 32'h4;
    inst_ready = 1'b0;
    @(negedge clock);
    imem_gnt = 1'b1;
    sb.push_back({1'b0, 32'h4, 32'h00A0_0113});
    @(negedge clock);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00A0_0113;
    @(negedge clock);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00A0_0113 || inst_pc !== 32'h4 ||
          pc_write_enable !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b inst=%h pc=%h pwe=%b req=%b, need 1 00a00113 4 0 0",
                 i, inst_valid, inst, inst_pc, pc_write_enable, imem_req);
      end
      if (i < 4) @(negedge clock);
    end
    inst_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (inst_valid !== 1'b0 || pc_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b pwe=%b, need 0 0", inst_valid, pc_write_enable);
    end
  endtask
  task automatic test_redirect_data();
    pc = 32'h8;
    inst_ready = 1'b1;
    @(negedge clock);
    imem_gnt = 1'b1;
    @(negedge clock);
    imem_gnt = 1'b0;
    redirect = 1'b1;
    pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL redir_data_%0d: valid=%b req=%b, need 0 0", i, inst_valid, imem_req);
      end
      imem_rvalid = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
    end
    fetch_ok(32'h40, 32'h0010_0073);
  endtask
  task automatic test_redirect_addr();
    pc = 32'h80;
    inst_ready = 1'b1;
    @(negedge clock);
    redirect = 1'b1;
    pc = 32'hC0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      redirect = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
        errors++;
        $display("FAIL redir_addr_hold_%0d: req=%b addr=%h, need 1 00000080", i, imem_req, imem_addr);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clock);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_1111;
    @(negedge clock);
    imem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_addr_drop: valid=%b, need 0", inst_valid);
    end
    fetch_ok(32'hC0, 32'h0020_0193);
  endtask
  task automatic test_redirect_vs_ready();
    pc = 32'h100;
    inst_ready = 1'b0;
    @(negedge clock);
    imem_gnt = 1'b1;
    @(negedge clock);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_0013;
    @(negedge clock);
    imem_rvalid = 1'b0;
    redirect = 1'b1;
    inst_ready = 1'b1;
    pc = 32'h200;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0013 || pc_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL redir_ready: valid=%b inst=%h pwe=%b, need 1 cafe0013 0", inst_valid, inst, pc_write_enable);
    end
    @(negedge clock);
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_ready_idle: valid=%b, need 0", inst_valid);
    end
  endtask
  task automatic test_misaligned();
    pc = 32'h102;
    inst_ready = 1'b1;
    sb.push_back({1'b1, 32'h102, 32'h0000_0013});
    @(negedge clock);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_fault !== 1'b1 ||
        inst !== 32'h0000_0013 || inst_pc !== 32'h102) begin
      errors++;
      $display("FAIL misaligned: req=%b valid=%b fault=%b inst=%h pc=%h, need 0 1 1 00000013 00000102",
               imem_req, inst_valid, inst_fault, inst, inst_pc);
    end
    @(negedge clock);
    inst_ready = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_hold: valid=%b fault=%b req=%b, need 1 1 0", inst_valid, inst_fault, imem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_fault !== 1'b0 || inst !== 32'h0000_0013 ||
        inst_pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b fault=%b inst=%h pc=%h req=%b addr=%h, need 0 0 00000013 0 0 0",
               inst_valid, inst_fault, inst, inst_pc, imem_req, imem_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    fetch_ok(32'h0, 32'h0030_0213);
  endtask
  initial begin
    reset = 1'b1;
    pc = 32'h0;
    redirect = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_data();
    test_redirect_addr();
    test_redirect_vs_ready();
    test_misaligned();
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected handoffs never seen, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
